// File: rtl/fifo_burst_reader.sv
// Burst read controller: pops len words from a registered-output FIFO and replays them on a
// valid/ready stream through a 2-entry skid buffer. Optional stall counter: FIFO_RD_STALL_CNT_EN.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rden_o,
    input  logic                  empty_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
`ifdef FIFO_RD_STALL_CNT_EN
    output logic [15:0]           stall_cnt_o,
`endif
    output logic [DATA_WIDTH-1:0] m_data_o
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                 state, state_nxt;
    logic [LEN_WIDTH-1:0]   len_q, issued, delivered;
    logic [1:0]             occ;
    logic                   inflight_p1;
    logic                   wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0]  skid_mem [2];
    logic                   pop, rden;
    logic [2:0]             occ_after;

    assign m_valid_o = (occ != 2'd0);
    assign pop       = m_valid_o & m_ready_i;
    // Occupancy after this edge, ignoring any word requested this cycle.
    assign occ_after = {1'b0, occ} + {2'b00, inflight_p1} - {2'b00, pop};
    assign rden      = (state == READ) & ~empty_i & (issued < len_q) & (occ_after < 3'd2);
    assign rden_o    = rden;
    assign busy_o    = (state != IDLE);
    assign done_o    = (state == DONE);
    assign m_data_o  = m_valid_o ? skid_mem[rd_ptr] : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_i) state_nxt = (len_i != '0) ? READ : DONE;
            READ:  if (rden && (issued == len_q - 1'b1)) state_nxt = DRAIN;
            DRAIN: if (!inflight_p1 && (occ_after == 3'd0)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0 -> p1: FIFO request issued, data returns one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            len_q       <= '0;
            issued      <= '0;
            delivered   <= '0;
            occ         <= 2'd0;
            inflight_p1 <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
        end else begin
            state       <= state_nxt;
            inflight_p1 <= rden;
            occ         <= occ_after[1:0];
            if (inflight_p1) wr_ptr <= ~wr_ptr;
            if (pop)         rd_ptr <= ~rd_ptr;
            if ((state == IDLE) && start_i) begin
                len_q     <= len_i;
                issued    <= '0;
                delivered <= '0;
            end else begin
                if (rden) issued <= issued + 1'b1;
                if (pop && (delivered != len_q)) delivered <= delivered + 1'b1;
            end
        end
    end

    // Stage p1 -> skid: returning FIFO word lands at the tail.
    always_ff @(posedge clk) begin
        if (inflight_p1) skid_mem[wr_ptr] <= rdata_i;
    end

`ifdef FIFO_RD_STALL_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'h0000;
        end else if ((state == IDLE) && start_i) begin
            stall_cnt <= 16'h0000;
        end else if ((state == READ) && !rden && (empty_i || (occ_after >= 3'd2))
                     && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end

    assign stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: a queue-style FIFO model feeds the DUT and
// every delivered word is compared with the FIFO contents in pop order.
module tb_fifo_burst_reader;
    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start_i = 1'b0;
    logic [LW-1:0] len_i = '0;
    logic          busy_o, done_o, rden_o, empty_i, m_valid_o;
    logic [DW-1:0] rdata_i = '0;
    logic          m_ready_i = 1'b0;
    logic [DW-1:0] m_data_o;
`ifdef FIFO_RD_STALL_CNT_EN
    logic [15:0]   stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .rden_o(rden_o), .empty_i(empty_i),
        .rdata_i(rdata_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
`ifdef FIFO_RD_STALL_CNT_EN
        .stall_cnt_o(stall_cnt_o),
`endif
        .m_data_o(m_data_o)
    );

    // FIFO model with registered read data
    logic [DW-1:0] fmem [256];
    logic [7:0]    fwr = 8'd0, frd = 8'd0;
    logic          push_req = 1'b0;
    logic [DW-1:0] push_data = '0;

    assign empty_i = (fwr == frd);

    always @(posedge clk) begin
        if (push_req) begin
            fmem[fwr] <= push_data;
            fwr <= fwr + 8'd1;
        end
        if (rden_o && (fwr != frd)) begin
            rdata_i <= fmem[frd];
            frd <= frd + 8'd1;
        end
    end

    // Stream monitor
    int cyc = 0, rden_total = 0, rden_run = 0, rden_maxrun = 0;
    int done_cnt = 0, done_cyc = 0, hold_viol = 0, occ_viol = 0, underflow = 0, valid_cnt = 0;
    logic [DW-1:0] got_q [$];
    int            got_cyc [$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (m_valid_o) valid_cnt <= valid_cnt + 1;
        if (m_valid_o && m_ready_i) begin
            got_q.push_back(m_data_o);
            got_cyc.push_back(cyc);
        end
        if (rst_n && prev_stall && (m_data_o !== prev_data)) hold_viol <= hold_viol + 1;
        prev_stall <= rst_n && m_valid_o && !m_ready_i;
        prev_data  <= m_data_o;
        if (rden_o) begin
            rden_total <= rden_total + 1;
            rden_run   <= rden_run + 1;
            if (rden_run + 1 > rden_maxrun) rden_maxrun <= rden_run + 1;
        end else begin
            rden_run <= 0;
        end
        if (rden_o && empty_i) underflow <= underflow + 1;
        if (done_o) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (dut.occ > 2'd2) occ_viol <= occ_viol + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [DW-1:0] base, input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            push_req  = 1'b1;
            push_data = rnd ? $urandom : base + DW'(i);
            tick();
        end
        push_req = 1'b0;
    endtask

    task automatic start_burst(input int len);
        start_i = 1'b1;
        len_i   = len[LW-1:0];
        tick();
        start_i = 1'b0;
        len_i   = '0;
    endtask

    // rmode: 0 ready high, 1 toggle, 2 random. Optionally pushes push_n words from iteration push_at.
    task automatic run_until_done(input int budget, input int rmode, input int push_at,
                                  input int push_n, output bit ok);
        int base_done = done_cnt;
        int pushed = 0;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            case (rmode)
                0: m_ready_i = 1'b1;
                1: m_ready_i = ~m_ready_i;
                default: m_ready_i = 1'($urandom_range(0, 1));
            endcase
            if (push_n > 0 && i >= push_at && pushed < push_n) begin
                push_req  = 1'b1;
                push_data = 32'h200 + DW'(pushed);
                pushed++;
            end else begin
                push_req = 1'b0;
            end
            tick();
            if (done_cnt != base_done) ok = 1'b1;
        end
        push_req = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, rden_o, m_valid_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000", {busy_o, done_o, rden_o, m_valid_o});
        end
        checks++;
        if (m_data_o !== '0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", m_data_o);
        end
`ifdef FIFO_RD_STALL_CNT_EN
        checks++;
        if (stall_cnt_o !== 16'h0) begin
            errors++;
            $display("FAIL reset_stall got %0d want 0", stall_cnt_o);
        end
`endif
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_rate();
        int gb = got_q.size();
        int rb = rden_total;
        int dc = done_cnt;
        int n;
        bit ok;
        push_words(32'h0, 8, 1'b0);
        m_ready_i = 1'b1;
        start_burst(8);
        run_until_done(60, 0, 0, 0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL full_done_timeout got none want done"); end
        n = got_q.size() - gb;
        checks++;
        if (n != 8) begin errors++; $display("FAIL full_count got %0d want 8", n); end
        for (int i = 0; i < 8 && i < n; i++) begin
            checks++;
            if (got_q[gb+i] !== DW'(i)) begin
                errors++;
                $display("FAIL full_data[%0d] got %h want %h", i, got_q[gb+i], i);
            end
        end
        if (n == 8) begin
            checks++;
            if (got_cyc[gb+7] - got_cyc[gb] != 7) begin
                errors++;
                $display("FAIL full_consecutive span got %0d want 7", got_cyc[gb+7] - got_cyc[gb]);
            end
            checks++;
            if (done_cyc != got_cyc[gb+7] + 1) begin
                errors++;
                $display("FAIL full_done_timing got %0d want %0d", done_cyc, got_cyc[gb+7] + 1);
            end
        end
        checks++;
        if (rden_total - rb != 8) begin
            errors++;
            $display("FAIL full_rden_count got %0d want 8", rden_total - rb);
        end
        checks++;
        if (rden_maxrun != 8) begin
            errors++;
            $display("FAIL full_rden_run got %0d want 8", rden_maxrun);
        end
        tick();
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL full_busy_after got %b want 0", busy_o); end
        checks++;
        if (done_cnt - dc != 1) begin
            errors++;
            $display("FAIL full_done_pulses got %0d want 1", done_cnt - dc);
        end
    endtask

    task automatic test_backpressure();
        int gb = got_q.size();
        int hv = hold_viol;
        int n;
        logic [7:0] rd0;
        bit ok;
        push_words('0, 8, 1'b1);
        rd0 = frd;
        m_ready_i = 1'b0;
        start_burst(8);
        run_until_done(100, 1, 0, 0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_done_timeout got none want done"); end
        n = got_q.size() - gb;
        checks++;
        if (n != 8) begin errors++; $display("FAIL bp_count got %0d want 8", n); end
        for (int i = 0; i < 8 && i < n; i++) begin
            checks++;
            if (got_q[gb+i] !== fmem[rd0 + 8'(i)]) begin
                errors++;
                $display("FAIL bp_data[%0d] got %h want %h", i, got_q[gb+i], fmem[rd0 + 8'(i)]);
            end
        end
        checks++;
        if (hold_viol != hv) begin errors++; $display("FAIL bp_hold got %0d want 0", hold_viol - hv); end
        checks++;
        if (occ_viol != 0) begin errors++; $display("FAIL bp_occ got %0d want 0", occ_viol); end
    endtask

    task automatic test_empty_stall();
        int gb = got_q.size();
        int n;
        logic [DW-1:0] exp [5];
        bit ok;
        exp[0] = 32'h100; exp[1] = 32'h101; exp[2] = 32'h102; exp[3] = 32'h200; exp[4] = 32'h201;
        push_words(32'h100, 3, 1'b0);
        start_burst(5);
        run_until_done(200, 0, 14, 2, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_done_timeout got none want done"); end
        n = got_q.size() - gb;
        checks++;
        if (n != 5) begin errors++; $display("FAIL stall_count got %0d want 5", n); end
        for (int i = 0; i < 5 && i < n; i++) begin
            checks++;
            if (got_q[gb+i] !== exp[i]) begin
                errors++;
                $display("FAIL stall_data[%0d] got %h want %h", i, got_q[gb+i], exp[i]);
            end
        end
        checks++;
        if (underflow != 0) begin errors++; $display("FAIL stall_underflow got %0d want 0", underflow); end
`ifdef FIFO_RD_STALL_CNT_EN
        begin
            logic [15:0] held;
            checks++;
            if (stall_cnt_o < 16'd10) begin
                errors++;
                $display("FAIL stall_cnt got %0d want >=10", stall_cnt_o);
            end
            held = stall_cnt_o;
            tick(); tick(); tick();
            checks++;
            if (stall_cnt_o !== held) begin
                errors++;
                $display("FAIL stall_cnt_hold got %0d want %0d", stall_cnt_o, held);
            end
        end
`endif
    endtask

    task automatic test_zero_len();
        int rb = rden_total;
        int dc = done_cnt;
        int vc = valid_cnt;
        logic [7:0] rd0;
        bit ok;
        push_words('0, 2, 1'b1);
        rd0 = frd;
        m_ready_i = 1'b1;
        start_burst(0);
        run_until_done(2, 0, 0, 0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL zero_done_timing got none want done within 2"); end
        tick(); tick();
        checks++;
        if (rden_total != rb) begin errors++; $display("FAIL zero_rden got %0d want 0", rden_total - rb); end
        checks++;
        if (valid_cnt != vc) begin errors++; $display("FAIL zero_valid got %0d want 0", valid_cnt - vc); end
        checks++;
        if (done_cnt - dc != 1) begin errors++; $display("FAIL zero_done_pulses got %0d want 1", done_cnt - dc); end
        checks++;
        if (frd !== rd0) begin errors++; $display("FAIL zero_fifo_untouched got %0d want %0d", frd, rd0); end
    endtask

    task automatic test_reset_midburst();
        int gb = got_q.size();
        int dc = done_cnt;
        int gb2, n;
        logic [7:0] rd0;
        bit ok;
        push_words('0, 8, 1'b1);
        m_ready_i = 1'b1;
        start_burst(8);
        for (int i = 0; i < 50 && (got_q.size() - gb) < 3; i++) tick();
        checks++;
        if (got_q.size() - gb != 3) begin
            errors++;
            $display("FAIL rst_pre_transfers got %0d want 3", got_q.size() - gb);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, rden_o, m_valid_o} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_ctrl got %b want 0000", {busy_o, done_o, rden_o, m_valid_o});
        end
        checks++;
        if (m_data_o !== '0) begin errors++; $display("FAIL rst_mid_data got %h want 0", m_data_o); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (done_cnt != dc) begin errors++; $display("FAIL rst_mid_done got %0d want 0", done_cnt - dc); end
        rd0 = frd;
        gb2 = got_q.size();
        start_burst(4);
        run_until_done(80, 2, 0, 0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_new_timeout got none want done"); end
        n = got_q.size() - gb2;
        checks++;
        if (n != 4) begin errors++; $display("FAIL rst_new_count got %0d want 4", n); end
        for (int i = 0; i < 4 && i < n; i++) begin
            checks++;
            if (got_q[gb2+i] !== fmem[rd0 + 8'(i)]) begin
                errors++;
                $display("FAIL rst_new_data[%0d] got %h want %h", i, got_q[gb2+i], fmem[rd0 + 8'(i)]);
            end
        end
    endtask

    task automatic test_restart_ignored();
        int gb, dc, n;
        logic [7:0] rd0;
        bit ok;
        push_words(32'h300, 6, 1'b0);
        rd0 = frd;
        gb = got_q.size();
        dc = done_cnt;
        m_ready_i = 1'b0;
        start_burst(6);
        tick(); tick();
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL restart_busy got %b want 1", busy_o); end
        start_i = 1'b1;
        len_i = 8'd3;
        tick();
        start_i = 1'b0;
        len_i = '0;
        run_until_done(100, 2, 0, 0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL restart_timeout got none want done"); end
        tick(); tick(); tick();
        n = got_q.size() - gb;
        checks++;
        if (n != 6) begin errors++; $display("FAIL restart_count got %0d want 6", n); end
        for (int i = 0; i < 6 && i < n; i++) begin
            checks++;
            if (got_q[gb+i] !== fmem[rd0 + 8'(i)]) begin
                errors++;
                $display("FAIL restart_data[%0d] got %h want %h", i, got_q[gb+i], fmem[rd0 + 8'(i)]);
            end
        end
        checks++;
        if (done_cnt - dc != 1) begin errors++; $display("FAIL restart_done got %0d want 1", done_cnt - dc); end
    endtask

    task automatic test_random_bursts();
        for (int it = 0; it < 5; it++) begin
            int len = int'($urandom_range(1, 20));
            int gb, n;
            logic [7:0] rd0;
            bit ok;
            push_words('0, len + int'($urandom_range(0, 2)), 1'b1);
            rd0 = frd;
            gb = got_q.size();
            start_burst(len);
            run_until_done(400, 2, 0, 0, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rand%0d_timeout got none want done", it); end
            n = got_q.size() - gb;
            checks++;
            if (n != len) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", it, n, len); end
            for (int i = 0; i < len && i < n; i++) begin
                checks++;
                if (got_q[gb+i] !== fmem[rd0 + 8'(i)]) begin
                    errors++;
                    $display("FAIL rand%0d_data[%0d] got %h want %h", it, i, got_q[gb+i], fmem[rd0 + 8'(i)]);
                end
            end
        end
        checks++;
        if (underflow != 0) begin errors++; $display("FAIL final_underflow got %0d want 0", underflow); end
        checks++;
        if (hold_viol != 0) begin errors++; $display("FAIL final_hold got %0d want 0", hold_viol); end
        checks++;
        if (occ_viol != 0) begin errors++; $display("FAIL final_occ got %0d want 0", occ_viol); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_rate();
        test_backpressure();
        test_empty_stall();
        test_zero_len();
        test_reset_midburst();
        test_restart_ignored();
        test_random_bursts();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
